uart_tx_frame: RTL

Parametrised UART transmitter: serialises DATA_BITS-wide words onto a single `tx` line with configurable bit period, optional parity and 1 or 2 stop bits. Input uses a valid/ready handshake backed by an optional word FIFO, so back-to-back frames leave the line with no idle gap. It sits between on-chip producers (ACK/NAK responders, debug streams) and the board TX pin, replacing the fixed 8N1 transmitter.

---
 rtl/uart_tx_frame.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_BITS payload (LSB first), optional parity, 1-2 stop bits.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH word input FIFO; otherwise a single holding register.
module uart_tx_frame #(
  parameter int CLK_DIV    = 10415,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 tx_done,
  output logic                 busy
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_frame: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLK_DIV - 2);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state;
  logic [BW-1:0]          baud;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_bit;
  logic                   alive;

  logic                   push;
  logic                   pop;
  logic                   empty;
  logic                   full;
  logic [DATA_BITS-1:0]   head;

  assign ready = alive && !full;
  assign push  = valid && ready;
  assign pop   = !empty && ((state == IDLE) ||
                 (state == STOP && baud == BAUD_LAST && bit_cnt == STOP_LAST));

  // ready stays low through reset and rises one edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

`ifdef UART_TX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW:0]          count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(FIFO_DEPTH));
`else
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;

  // push needs the register empty and pop needs it full, so they never coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (pop) begin
      hold_full <= 1'b0;
    end else if (push) begin
      hold      <= data_in;
      hold_full <= 1'b1;
    end
  end

  assign head  = hold;
  assign empty = !hold_full;
  assign full  = hold_full;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
      busy    <= 1'b0;
    end else begin
      tx_done <= (state == STOP) && (bit_cnt == STOP_LAST) && (baud == BAUD_PRE);
      if (state != IDLE) baud <= (baud == BAUD_LAST) ? '0 : baud + 1'b1;

      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift   <= head;
            par_bit <= ^head ^ PAR_ODD;
            state   <= START;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx      <= shift[0];
            shift   <= shift >> 1;
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            if (bit_cnt != DATA_LAST) begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end else if (PARITY != 0) begin
              state   <= PAR;
              tx      <= par_bit;
            end else begin
              state   <= STOP;
              bit_cnt <= '0;
              tx      <= 1'b1;
            end
          end
        end
        PAR: begin
          if (baud == BAUD_LAST) begin
            state   <= STOP;
            bit_cnt <= '0;
            tx      <= 1'b1;
          end
        end
        STOP: begin
          if (baud == BAUD_LAST) begin
            if (bit_cnt != STOP_LAST) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (pop) begin
              // next frame starts straight from the stop bit, no idle cycle
              shift   <= head;
              par_bit <= ^head ^ PAR_ODD;
              state   <= START;
              tx      <= 1'b0;
            end else begin
              state   <= IDLE;
              tx      <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
